// File: rtl/overlap_add_stream.sv
`default_nettype none
// ============================================================================
// Module   : overlap_add_stream
// Overlap-adds consecutive (y0,y1,y2) product triples with a 2-segment stride
// and serialises them over valid/ready; flush emits the final carry.
// Revision : 1.0
// ============================================================================
module overlap_add_stream #(
  parameter int IW     = 7,
  parameter int OW     = 8,
  parameter int BCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IW-1:0]     in_y0,
  input  logic [IW-1:0]     in_y1,
  input  logic [IW-1:0]     in_y2,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OW-1:0]     out_data,
  output logic              out_last,
  output logic [BCNT_W-1:0] blk_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT0 = 2'd1,
    EMIT1 = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [OW-1:0]       carry_q, carry_d;
  logic [OW-1:0]       data1_q, data1_d;
  logic [OW-1:0]       out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [BCNT_W-1:0]   blk_q, blk_d;
  logic [OW-1:0]       y0_ext, y1_ext, y2_ext;

  assign y0_ext = {{(OW-IW){1'b0}}, in_y0};
  assign y1_ext = {{(OW-IW){1'b0}}, in_y1};
  assign y2_ext = {{(OW-IW){1'b0}}, in_y2};

  assign in_ready  = (state_q == IDLE) & rst_n;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign blk_count = blk_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      carry_q     <= '0;
      data1_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      blk_q       <= '0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      data1_q     <= data1_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      blk_q       <= blk_d;
    end
  end

  // Output registers are loaded with the word of the state being entered,
  // so every output is registered and holds while the consumer stalls.
  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    data1_d     = data1_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    blk_d       = blk_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d     = EMIT0;
          out_data_d  = y0_ext + carry_q;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          data1_d     = y1_ext;
          carry_d     = y2_ext;
          if (blk_q != '1) blk_d = blk_q + BCNT_W'(1);
        end else if (flush) begin
          state_d     = FLUSH;
          out_data_d  = carry_q;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
        end
      end
      EMIT0: begin
        if (out_ready) begin
          state_d    = EMIT1;
          out_data_d = data1_q;
        end
      end
      EMIT1: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      FLUSH: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          carry_d     = '0;
          blk_d       = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_overlap_add_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_overlap_add_stream
// Scoreboard bench for overlap_add_stream (IW=7, OW=8, BCNT_W=2).
// Revision : 1.0
// ============================================================================
module tb_overlap_add_stream;

  localparam int IW     = 7;
  localparam int OW     = 8;
  localparam int BCNT_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IW-1:0]     in_y0 = '0;
  logic [IW-1:0]     in_y1 = '0;
  logic [IW-1:0]     in_y2 = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OW-1:0]     out_data;
  logic              out_last;
  logic [BCNT_W-1:0] blk_count;

  overlap_add_stream #(.IW(IW), .OW(OW), .BCNT_W(BCNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y0     (in_y0),
    .in_y1     (in_y1),
    .in_y2     (in_y2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .blk_count (blk_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state and scoreboard of {last, data}
  logic [OW:0]       sb[$];
  logic [OW-1:0]     m_carry = '0;
  logic [BCNT_W-1:0] m_blk = '0;
  logic              rst_seen = 1'b0;
  logic              hold_v = 1'b0;
  logic [OW-1:0]     hold_d = '0;
  logic              hold_l = 1'b0;
  logic              rand_bp = 1'b0;

  // Monitor: samples at negedge, i.e. the values the next posedge acts on
  always @(negedge clk) begin
    logic [OW:0]   exp_w;
    logic [OW-1:0] s;
    if (!rst_n) begin
      check_eq("in_ready_in_reset", in_ready, 0);
      sb.delete();
      m_carry  = '0;
      m_blk    = '0;
      rst_seen = 1'b1;
      hold_v   = 1'b0;
    end else begin
      if (rst_seen) begin
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_last", out_last, 0);
        rst_seen = 1'b0;
      end
      check_eq("blk_count", blk_count, m_blk);
      if (hold_v) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_data", out_data, hold_d);
        check_eq("hold_last", out_last, hold_l);
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      if (out_valid && out_ready) begin
        check_eq("sb_has_word", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_w = sb.pop_front();
          check_eq("out_data", out_data, exp_w[OW-1:0]);
          check_eq("out_last", out_last, exp_w[OW]);
        end
        if (out_last) begin
          m_carry = '0;
          m_blk   = '0;
        end
      end
      if (in_valid && in_ready) begin
        s = {1'b0, in_y0} + m_carry;
        sb.push_back({1'b0, s});
        sb.push_back({1'b0, 1'b0, in_y1});
        m_carry = {1'b0, in_y2};
        if (m_blk != {BCNT_W{1'b1}}) m_blk = m_blk + 1'b1;
      end else if (flush && in_ready) begin
        sb.push_back({1'b1, m_carry});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_block(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic [IW-1:0] c);
    logic ok;
    ok = 1'b0;
    in_y0 = a; in_y1 = b; in_y2 = c;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check_eq("block_accepted", ok, 1);
  endtask

  task automatic wait_last();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) ok = 1'b1;
      step();
    end
    flush = 1'b0;
    check_eq("flush_done", ok, 1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    wait_last();
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) ok = 1'b1;
      step();
    end
    check_eq("drained", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Basic overlap-add then flush
    send_block(7'd3, 7'd5, 7'd7);
    send_block(7'd1, 7'd2, 7'd4);
    check_eq("blk_after_two", blk_count, 2);
    do_flush();
    check_eq("blk_after_flush", blk_count, 0);
    drain();

    // Max terms, no overflow at OW bits
    send_block(7'd127, 7'd127, 7'd127);
    send_block(7'd127, 7'd127, 7'd127);
    do_flush();
    drain();

    // Backpressure in EMIT0
    out_ready = 1'b0;
    send_block(7'd3, 7'd5, 7'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_data", out_data, 3);
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_first", out_data, 3);
    step();
    @(negedge clk);
    check_eq("bp_release_second", out_data, 5);
    step();
    drain();

    // in_valid and flush together: block wins, flush follows
    in_y0 = 7'd6; in_y1 = 7'd1; in_y2 = 7'd9;
    in_valid = 1'b1;
    flush = 1'b1;
    begin
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        if (in_ready) ok = 1'b1;
        step();
      end
      in_valid = 1'b0;
      check_eq("combo_accepted", ok, 1);
    end
    wait_last();
    do_flush();
    drain();

    // Reset during EMIT1 discards pending word and carry
    send_block(7'd1, 7'd2, 7'd3);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", out_valid, 0);
    step();
    send_block(7'd2, 7'd0, 7'd0);
    drain();

    // Counter saturation at BCNT_W=2
    repeat (5) send_block(7'd1, 7'd1, 7'd1);
    check_eq("blk_saturated", blk_count, 3);
    do_flush();
    check_eq("blk_sat_flush", blk_count, 0);
    drain();

    // Random blocks with random backpressure
    rand_bp = 1'b1;
    repeat (8) send_block(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                          7'($urandom_range(0, 127)));
    do_flush();
    rand_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    check_eq("sb_empty_end", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
